// File: rtl/mul_seq_ctrl.sv
// rtl/mul_seq_ctrl.sv - RV32M multiply sequencer (MUL/MULH/MULHSU/MULHU)
// Shift-and-add over one shared external adder; signs handled by pre/post negation.
module mul_seq_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            ready,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [XLEN-1:0] add_a,
  output logic [XLEN-1:0] add_b,
  input  logic [XLEN-1:0] add_sum
);

  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [XLEN-1:0] ONE  = {{(XLEN-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE, NEG_A, NEG_B, ITER, NEG_LO, NEG_HI, DONE
  } state_t;

  state_t          state;
  logic [1:0]      op_q;
  logic [XLEN-1:0] mcand, lo, hi;
  logic [CW-1:0]   cnt;
  logic            sb_q, neg_q, lcy;

  logic            sa_in, sb_in, carry;
  logic [XLEN-1:0] iter_hi, iter_lo;

  assign sa_in = src_a[XLEN-1] & ((op == OP_MULH) | (op == OP_MULHSU));
  assign sb_in = src_b[XLEN-1] & (op == OP_MULH);

  assign ready = (state == IDLE);
  assign done  = (state == DONE);

  always_comb begin
    add_a = '0;
    add_b = '0;
    case (state)
      NEG_A:  begin add_a = ~mcand; add_b = ONE; end
      NEG_B:  begin add_a = ~lo;    add_b = ONE; end
      ITER:   begin add_a = hi;     add_b = lo[0] ? mcand : '0; end
      NEG_LO: begin add_a = ~lo;    add_b = ONE; end
      NEG_HI: begin add_a = ~hi;    add_b = {{(XLEN-1){1'b0}}, lcy}; end
      default: ;
    endcase
  end

  // Carry-out recovered from the MSBs since the shared adder exposes none.
  assign carry = (add_a[XLEN-1] & add_b[XLEN-1]) |
                 ((add_a[XLEN-1] | add_b[XLEN-1]) & ~add_sum[XLEN-1]);
  assign iter_hi = {carry, add_sum[XLEN-1:1]};
  assign iter_lo = {add_sum[0], lo[XLEN-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      mcand  <= '0;
      lo     <= '0;
      hi     <= '0;
      cnt    <= '0;
      sb_q   <= 1'b0;
      neg_q  <= 1'b0;
      lcy    <= 1'b0;
      result <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= op;
            mcand <= src_a;
            lo    <= src_b;
            hi    <= '0;
            cnt   <= '0;
            sb_q  <= sb_in;
            neg_q <= sa_in ^ sb_in;
            state <= sa_in ? NEG_A : (sb_in ? NEG_B : ITER);
          end
        end
        NEG_A: begin
          mcand <= add_sum;
          state <= sb_q ? NEG_B : ITER;
        end
        NEG_B: begin
          lo    <= add_sum;
          state <= ITER;
        end
        ITER: begin
          hi  <= iter_hi;
          lo  <= iter_lo;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN - 1)) begin
            if (neg_q) begin
              state <= NEG_LO;
            end else begin
              result <= (op_q == OP_MUL) ? iter_lo : iter_hi;
              state  <= DONE;
            end
          end
        end
        NEG_LO: begin
          lo    <= add_sum;
          lcy   <= (lo == '0);
          state <= NEG_HI;
        end
        NEG_HI: begin
          hi     <= add_sum;
          result <= (op_q == OP_MUL) ? lo : add_sum;
          state  <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// tb/tb_mul_seq_ctrl.sv - self-checking bench for mul_seq_ctrl
// Table vectors, randomized ops vs a 64-bit arithmetic model, and abort sequences.
module tb_mul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0, src_b = '0;
  logic        flush = 1'b0;
  logic        ready, done;
  logic [31:0] result, add_a, add_b, add_sum;

  int checks = 0;
  int failures = 0;

  assign add_sum = add_a + add_b;

  mul_seq_ctrl #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .ready(ready), .done(done), .result(result),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          n;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] ea, eb, p;
    ea = ((o == 2'b01 || o == 2'b10) && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
    eb = (o == 2'b01 && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = ((o == 2'b01 || o == 2'b10) && a[31]) ? 1 : 0;
    sb = (o == 2'b01 && b[31]) ? 1 : 0;
    return 33 + sa + sb + 2 * (sa ^ sb);
  endfunction

  // Present a request, count edges from the accepting edge until done is seen.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] r, output int n, output bit ok);
    op = o; src_a = a; src_b = b; start = 1'b1;
    ok = 1'b0; r = '0; n = 0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 100) begin
      if (done) begin
        ok = 1'b1;
        r = result;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic check_op(input string name, input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input int en);
    logic [31:0] r;
    int n;
    bit ok;
    run_op(o, a, b, r, n, ok);
    chk({name, " done_seen"}, ok, 1);
    if (ok) begin
      chk({name, " result"}, r, er);
      chk({name, " latency"}, n, en);
      chk({name, " adder_quiet_done"}, {add_a, add_b}, 64'h0);
      @(posedge clk); #1;
      chk({name, " single_pulse"}, {done, ready}, 2'b01);
    end
  endtask

  initial begin
    vec_t tbl[$];
    logic [31:0] r, held;
    int n;
    bit ok;
    bit seen;

    tbl.push_back('{2'b00, 32'd7,          32'd6,          32'h0000_002A, 33});
    tbl.push_back('{2'b11, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE, 33});
    tbl.push_back('{2'b01, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 35});
    tbl.push_back('{2'b01, 32'h8000_0000,  32'h0000_0002,  32'hFFFF_FFFF, 36});
    tbl.push_back('{2'b10, 32'hFFFF_FFFE,  32'h0000_0003,  32'hFFFF_FFFF, 36});
    tbl.push_back('{2'b00, 32'hFFFF_FFFE,  32'h0000_0003,  32'hFFFF_FFFA, 33});
    tbl.push_back('{2'b01, 32'h8000_0000,  32'h8000_0000,  32'h4000_0000, 35});
    tbl.push_back('{2'b01, 32'h0000_0005,  32'hFFFF_FFFD,  32'hFFFF_FFFF, 36});

    repeat (3) @(posedge clk);
    #1;
    chk("reset ready/done", {ready, done}, 2'b10);
    chk("reset result", result, 32'h0);
    chk("reset adder", {add_a, add_b}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++)
      check_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].res, tbl[i].n);

    for (int i = 0; i < 30; i++) begin
      logic [1:0] o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      if (i % 5 == 0) a = 32'h8000_0000;
      if (i % 7 == 0) b = 32'hFFFF_FFFF;
      check_op($sformatf("rand%0d", i), o, a, b, ref_mul(o, a, b), ref_lat(o, a, b));
    end

    // flush on the 10th ITER cycle: no done, result untouched
    held = result;
    op = 2'b00; src_a = 32'd100; src_b = 32'd200; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("flush busy", ready, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush ready", {ready, done}, 2'b10);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("flush no_done", seen, 1'b0);
    chk("flush result_held", result, held);
    check_op("after_flush", 2'b00, 32'd3, 32'd5, 32'h0000_000F, 33);

    // flush beats start
    op = 2'b11; src_a = 32'd9; src_b = 32'd9; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    chk("flush_vs_start ready", ready, 1'b1);
    chk("flush_vs_start adder", {add_a, add_b}, 64'h0);

    // start presented while in DONE is ignored
    run_op(2'b11, 32'd2, 32'd3, r, n, ok);
    chk("done_start done_seen", ok, 1);
    start = 1'b1;
    @(posedge clk); #1;
    chk("done_start ignored", ready, 1'b1);
    start = 1'b0;

    // asynchronous reset mid-ITER
    op = 2'b01; src_a = 32'hFFFF_FFF0; src_b = 32'd11; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst ready/done", {ready, done}, 2'b10);
    chk("rst result", result, 32'h0);
    chk("rst adder", {add_a, add_b}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("rst no_done", seen, 1'b0);
    check_op("after_rst", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
             ref_mul(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 36);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
